// File: rtl/recolector.sv
// Round-robin collector: drains output FIFOs 4..7 one word at a time onto a
// valid/ready stream, and keeps a per-source word count.
//
// state | meaning
// IDLE  | wait for a non-empty FIFO, latch grant from round-robin pointer
// POP   | pop strobe high for the granted FIFO
// LOAD  | FIFO read data valid; captured into data_out on exit
// SEND  | valid_out high, hold word until ready_in
module recolector #(
   parameter int DATA_W = 10,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] fifo4_out,
   input  logic [DATA_W-1:0] fifo5_out,
   input  logic [DATA_W-1:0] fifo6_out,
   input  logic [DATA_W-1:0] fifo7_out,
   input  logic              fifo4_empty,
   input  logic              fifo5_empty,
   input  logic              fifo6_empty,
   input  logic              fifo7_empty,
   output logic              pop4,
   output logic              pop5,
   output logic              pop6,
   output logic              pop7,
   output logic [DATA_W-1:0] data_out,
   output logic [1:0]        src_out,
   output logic              valid_out,
   input  logic              ready_in,
   input  logic [1:0]        cnt_sel,
   output logic [CNT_W-1:0]  cnt_q,
   input  logic              cnt_clr
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_POP,
      S_LOAD,
      S_SEND
   } state_t;

   state_t            state_q;
   logic [1:0]        ptr_q;
   logic [1:0]        grant_q;
   logic [1:0]        grant_d;
   logic [1:0]        idx_d;
   logic [3:0]        pop_q;
   logic [DATA_W-1:0] data_q;
   logic [1:0]        src_q;
   logic              valid_q;
   logic [CNT_W-1:0]  cnt_arr_q [4];

   logic [3:0]        empty_vec;
   logic [DATA_W-1:0] fifo_data [4];

   assign empty_vec    = {fifo7_empty, fifo6_empty, fifo5_empty, fifo4_empty};
   assign fifo_data[0] = fifo4_out;
   assign fifo_data[1] = fifo5_out;
   assign fifo_data[2] = fifo6_out;
   assign fifo_data[3] = fifo7_out;

   // Scan from the farthest offset down so the nearest non-empty FIFO wins.
   always_comb begin
      grant_d = ptr_q;
      idx_d   = ptr_q;
      for (int i = 3; i >= 0; i--) begin
         idx_d = ptr_q + 2'(i);
         if (!empty_vec[idx_d]) grant_d = idx_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         pop_q   <= '0;
         data_q  <= '0;
         src_q   <= '0;
         valid_q <= 1'b0;
         for (int k = 0; k < 4; k++) cnt_arr_q[k] <= '0;
      end else begin
         pop_q <= '0;
         case (state_q)
            S_IDLE: begin
               if (!(&empty_vec)) begin
                  grant_q         <= grant_d;
                  pop_q[grant_d]  <= 1'b1;
                  state_q         <= S_POP;
               end
            end
            S_POP: begin
               state_q <= S_LOAD;
            end
            S_LOAD: begin
               data_q  <= fifo_data[grant_q];
               src_q   <= grant_q;
               valid_q <= 1'b1;
               state_q <= S_SEND;
            end
            S_SEND: begin
               if (ready_in) begin
                  valid_q            <= 1'b0;
                  ptr_q              <= grant_q + 2'd1;
                  cnt_arr_q[grant_q] <= cnt_arr_q[grant_q] + CNT_W'(1);
                  state_q            <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
         // Clear is the last write so it overrides a same-cycle increment.
         if (cnt_clr) begin
            for (int k = 0; k < 4; k++) cnt_arr_q[k] <= '0;
         end
      end
   end

   assign pop4      = pop_q[0];
   assign pop5      = pop_q[1];
   assign pop6      = pop_q[2];
   assign pop7      = pop_q[3];
   assign data_out  = data_q;
   assign src_out   = src_q;
   assign valid_out = valid_q;
   assign cnt_q     = cnt_arr_q[cnt_sel];

endmodule

// File: doc/recolector.md
RECOLECTOR -- requirements
Module: recolector

Interface
REQ-001 Parameter DATA_W, default 10: width of every data word.
REQ-002 Parameter CNT_W, default 8: width of each per-port word counter.
REQ-003 The block SHALL use one clock and a synchronous, active-low reset, with ports as follows.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-006 fifo4_out..fifo7_out  input  DATA_W each  read data of output FIFOs 4..7; valid the cycle after the matching pop.
REQ-007 fifo4_empty..fifo7_empty  input  1 each  FIFO empty flags.
REQ-008 pop4..pop7  output  1 each  FIFO read strobes, one word per high cycle.
REQ-009 data_out  output  DATA_W  collected word.
REQ-010 src_out  output  2  source of data_out; 0..3 map to FIFO4..FIFO7.
REQ-011 valid_out  output  1  data_out/src_out valid.
REQ-012 ready_in  input  1  downstream accepts the word when valid_out && ready_in.
REQ-013 cnt_sel  input  2  counter select; 0..3 map to FIFO4..FIFO7.
REQ-014 cnt_q  output  CNT_W  combinational view of the selected counter.
REQ-015 cnt_clr  input  1  synchronous clear of all four counters.

Function
REQ-016 The FSM SHALL have states IDLE, POP, LOAD and SEND.
REQ-017 IDLE: if any empty flag is low, the block SHALL latch grant g = first non-empty FIFO in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4), then go to POP; otherwise it stays in IDLE.
REQ-018 POP: pop(4+g) SHALL be high for exactly this one cycle; all other pops are low; next state LOAD.
REQ-019 LOAD: on exit the block SHALL capture fifo(4+g)_out into data_out and g into src_out; next state SEND.
REQ-020 SEND: valid_out SHALL be high and data_out/src_out held stable until the handshake.
REQ-021 In SEND with ready_in=1 the block SHALL go to IDLE, set ptr <= g+1 (mod 4), and increment counter g.
REQ-022 valid_out SHALL be low in IDLE, POP and LOAD.
REQ-023 Pops SHALL be Moore outputs of the POP state only; at most one pop is high in any cycle, and never in IDLE, LOAD or SEND.
REQ-024 Latency: empty flag low sampled in IDLE at edge E0 -> pop high in the cycle after E0 -> valid_out high after edge E0+2.
REQ-025 Throughput SHALL be at most one word per 4 cycles with ready_in held high.
REQ-026 Empty flags SHALL be ignored outside IDLE.
REQ-027 Counters SHALL be CNT_W-bit and wrap from 2^CNT_W-1 to 0.
REQ-028 cnt_clr=1 SHALL zero all counters on the next edge; cnt_clr SHALL win over a simultaneous increment.
REQ-029 ptr SHALL change only on a SEND handshake; a starved FIFO is served within 4 grants.
REQ-030 ready_in high outside SEND SHALL have no effect.

Reset
REQ-031 With reset=0 at a rising edge, the block SHALL set state=IDLE, ptr=0, data_out=0, src_out=0, valid_out=0, all pops 0 and all counters 0.
REQ-032 Reset mid-operation (POP, LOAD or SEND) SHALL discard the in-flight word; a word already popped is lost and is not counted.
REQ-033 Reset SHALL take priority over cnt_clr and every FSM transition.

Verification
REQ-034 After reset, only fifo5 non-empty holding 10'h2A5, ready_in=1 -> pop5 high for exactly 1 cycle; valid_out high 2 cycles later with data_out=10'h2A5, src_out=1; cnt_sel=1 gives cnt_q=1.
REQ-035 All four FIFOs non-empty, 8 words drained with ready_in=1 -> src_out sequence 0,1,2,3,0,1,2,3; every counter=2.
REQ-036 ready_in=0 for 10 cycles during SEND -> valid_out stays high and data_out stays stable; no pop occurs; after ready_in=1 the word is counted once.
REQ-037 Counter 0 at 255 plus one more fifo4 word -> cnt_q=0; cnt_clr asserted on the handshake cycle -> counter=0, not 1.
REQ-038 reset=0 asserted in LOAD -> next cycle valid_out=0, all pops 0, state IDLE, counters 0, ptr=0.
REQ-039 All FIFOs empty for 20 cycles -> no pop and valid_out=0 throughout.
